// File: rtl/mul_share_pkg.sv
// Shared definitions for the multiplier-sharing controller.
//   W_DEF  : default operand/result width (matches the ALU multiplier)
//   CNT_W  : width of the settle-time counter (covers MUL_LAT up to 15)
//   state_e: controller state encoding; 2'b11 is unused and recovers to IDLE
package mul_share_pkg;

  localparam int W_DEF = 8;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/mul_share_ctrl_if.sv
// Bus bundle for mul_share_ctrl: two valid/ready request ports, the shared
// multiplier operand/product wires, the valid/ready result port and busy.
//   slave  : controller side (accepts requests, drives multiplier and result)
//   master : environment side (requesters, multiplier, result consumer)
interface mul_share_ctrl_if #(
  parameter int W = 8
);
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic [W-1:0] mul_c;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_id;
  logic         busy;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  mul_c, res_ready,
    output req0_ready, req1_ready,
    output mul_a, mul_b,
    output res_valid, res_data, res_id, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output mul_c, res_ready,
    input  req0_ready, req1_ready,
    input  mul_a, mul_b,
    input  res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/mul_share_ctrl_rr_arb2.sv
// Two-input round-robin grant, purely combinational.
//   req    : request vector (bit n = requester n valid)
//   prio   : requester preferred when both request
//   enable : grants are only issued when the parent may accept
//   gnt    : one-hot grant (zero when nothing granted)
//   gnt_id : index of the granted requester (0 when nothing granted)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       enable,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    if (enable) begin
      case (req)
        2'b01: gnt = 2'b01;
        2'b10: begin
          gnt    = 2'b10;
          gnt_id = 1'b1;
        end
        2'b11: begin
          gnt_id = prio;
          gnt    = prio ? 2'b10 : 2'b01;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one combinational W-bit signed multiplier between two requesters.
// A round-robin winner's operands are registered onto mul_a/mul_b, the
// product is sampled after MUL_LAT settle cycles and returned on the result
// port tagged with the owner's id.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request ports, multiplier wires, result port, busy
// Parameters: W (operand width), MUL_LAT (settle cycles, 1..15).
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int MUL_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_share_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic             prio_q;
  logic [W-1:0]     op_a_q, op_b_q;
  logic             op_id_q;
  logic [CNT_W-1:0] cnt_q;
  logic             res_valid_q;
  logic [W-1:0]     res_data_q;
  logic             res_id_q;

  logic             accept_en;
  logic             accept;
  logic             capture;
  logic             drop_res;
  logic [1:0]       gnt;
  logic             gnt_id;

  // Accepting is allowed in IDLE, or in HOLD while the consumer takes the
  // result. Gating with rst_n keeps both readies low during reset even
  // though the state register already reads IDLE.
  assign accept_en = rst_n &&
                     ((state_q == IDLE) || ((state_q == HOLD) && bus.res_ready));

  rr_arb2 u_arb (
    .req    ({bus.req1_valid, bus.req0_valid}),
    .prio   (prio_q),
    .enable (accept_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign accept = |gnt;

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    drop_res = 1'b0;
    case (state_q)
      IDLE: ;
      MUL: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          drop_res = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) state_d = MUL;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the operand and result registers are reset too, because they are
  // directly visible on mul_a/mul_b/res_data and must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q      <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= 1'b0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_a_q  <= gnt_id ? bus.req1_a : bus.req0_a;
        op_b_q  <= gnt_id ? bus.req1_b : bus.req0_b;
        op_id_q <= gnt_id;
        prio_q  <= ~gnt_id;
        cnt_q   <= CNT_W'(MUL_LAT - 1);
      end else if ((state_q == MUL) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (capture) begin
        res_valid_q <= 1'b1;
        res_data_q  <= bus.mul_c;
        res_id_q    <= op_id_q;
      end else if (drop_res) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.mul_a      = op_a_q;
  assign bus.mul_b      = op_b_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_id     = res_id_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Self-checking bench for mul_share_ctrl: one instance with MUL_LAT=1 for
// the functional and corner-case sequences, one with MUL_LAT=3 for the
// back-to-back throughput sequence. The shared multiplier is modelled here.
module tb_mul_share_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mul_share_ctrl_if #(.W(8)) bus1 ();
  mul_share_ctrl_if #(.W(8)) bus3 ();

  mul_share_ctrl #(.W(8), .MUL_LAT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  mul_share_ctrl #(.W(8), .MUL_LAT(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  // Shared combinational signed multipliers, low 8 bits of the product.
  logic signed [15:0] p1, p3;
  assign p1         = $signed(bus1.mul_a) * $signed(bus1.mul_b);
  assign p3         = $signed(bus3.mul_a) * $signed(bus3.mul_b);
  assign bus1.mul_c = p1[7:0];
  assign bus3.mul_c = p3[7:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus1.req0_valid = 0; bus1.req0_a = 0; bus1.req0_b = 0;
    bus1.req1_valid = 0; bus1.req1_a = 0; bus1.req1_b = 0;
    bus1.res_ready  = 0;
    bus3.req0_valid = 0; bus3.req0_a = 0; bus3.req0_b = 0;
    bus3.req1_valid = 0; bus3.req1_a = 0; bus3.req1_b = 0;
    bus3.res_ready  = 0;
  endtask

  task automatic drive_req1(input logic id, input logic v, input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      bus1.req1_valid = v; bus1.req1_a = a; bus1.req1_b = b;
    end else begin
      bus1.req0_valid = v; bus1.req0_a = a; bus1.req0_b = b;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // Wait (bounded) for res_valid on bus1; returns cycles waited.
  task automatic wait_res1(output int cyc);
    cyc = 0;
    while (!bus1.res_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // One isolated transaction on the MUL_LAT=1 instance.
  task automatic run_one(input vec_t v);
    int cyc;
    @(negedge clk);
    drive_req1(v.id, 1'b1, v.a, v.b);
    bus1.res_ready = 0;
    #1;
    check({v.name, "_ready_win"}, v.id ? bus1.req1_ready : bus1.req0_ready, 1);
    check({v.name, "_ready_lose"}, v.id ? bus1.req0_ready : bus1.req1_ready, 0);
    @(negedge clk);
    drive_req1(v.id, 1'b0, 8'h00, 8'h00);
    check({v.name, "_mul_a"}, bus1.mul_a, v.a);
    check({v.name, "_mul_b"}, bus1.mul_b, v.b);
    check({v.name, "_busy"}, bus1.busy, 1);
    wait_res1(cyc);
    check({v.name, "_latency"}, cyc, 1);
    check({v.name, "_data"}, bus1.res_data, v.exp);
    check({v.name, "_id"}, bus1.res_id, v.id);
    bus1.res_ready = 1;
    @(negedge clk);
    bus1.res_ready = 0;
    check({v.name, "_drop"}, bus1.res_valid, 0);
    check({v.name, "_idle"}, bus1.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int got;
    int last;
    int j;
    logic [7:0] exp2 [2];
    logic [7:0] oa [2];
    logic [7:0] ob [2];
    logic [7:0] exp6 [2];

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{"t1_fd_x_05",  1'b0, 8'hFD, 8'h05, 8'hF1};
    vecs[1] = '{"t3_127x127",  1'b0, 8'h7F, 8'h7F, 8'h01};
    vecs[2] = '{"t3_16x16",    1'b1, 8'h10, 8'h10, 8'h00};
    vecs[3] = '{"t3_m128xm1",  1'b1, 8'h80, 8'hFF, 8'h80};
    vecs[4] = '{"t_3x4_req1",  1'b1, 8'h03, 8'h04, 8'h0C};
    vecs[5] = '{"t_m9x9_req0", 1'b0, 8'hF7, 8'h09, 8'hAF};

    // Reset values, with both requesters asserting valid during reset.
    clear_inputs();
    rst_n = 0;
    bus1.req0_valid = 1;
    bus1.req1_valid = 1;
    #1;
    check("rst_req0_ready", bus1.req0_ready, 0);
    check("rst_req1_ready", bus1.req1_ready, 0);
    check("rst_res_valid", bus1.res_valid, 0);
    check("rst_res_data", bus1.res_data, 0);
    check("rst_res_id", bus1.res_id, 0);
    check("rst_busy", bus1.busy, 0);
    check("rst_mul_a", bus1.mul_a, 0);
    check("rst_mul_b", bus1.mul_b, 0);
    check("rst3_busy", bus3.busy, 0);
    repeat (2) @(negedge clk);
    clear_inputs();
    rst_n = 1;

    // Single-requester vectors, including the truncation cases.
    for (int i = 0; i < 6; i++) run_one(vecs[i]);

    // Both valid continuously: grants alternate starting with requester 0.
    do_reset();
    exp2[0] = 8'hF2;
    exp2[1] = 8'h0C;
    @(negedge clk);
    drive_req1(1'b0, 1'b1, 8'h07, 8'hFE);
    drive_req1(1'b1, 1'b1, 8'h03, 8'h04);
    bus1.res_ready = 1;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      check("t2_ready_excl", bus1.req0_ready & bus1.req1_ready, 0);
      if (bus1.res_valid) begin
        check("t2_id", bus1.res_id, got % 2);
        check("t2_data", bus1.res_data, exp2[got % 2]);
        got++;
      end
    end
    check("t2_results", got, 4);
    drive_req1(1'b0, 1'b0, 8'h00, 8'h00);
    drive_req1(1'b1, 1'b0, 8'h00, 8'h00);
    repeat (4) @(negedge clk);
    bus1.res_ready = 0;
    check("t2_idle", bus1.busy, 0);

    // Backpressure in HOLD with requester 1 waiting.
    do_reset();
    @(negedge clk);
    drive_req1(1'b0, 1'b1, 8'h05, 8'h03);
    @(negedge clk);
    drive_req1(1'b0, 1'b0, 8'h00, 8'h00);
    drive_req1(1'b1, 1'b1, 8'hFE, 8'hFE);
    check("t4_mul_no_accept", bus1.req1_ready, 0);
    wait_res1(cyc);
    check("t4_latency", cyc, 1);
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_valid", bus1.res_valid, 1);
      check("t4_hold_data", bus1.res_data, 8'h0F);
      check("t4_hold_id", bus1.res_id, 0);
      check("t4_hold_req1_ready", bus1.req1_ready, 0);
      @(negedge clk);
    end
    bus1.res_ready = 1;
    #1;
    check("t4_release_req1_ready", bus1.req1_ready, 1);
    check("t4_release_req0_ready", bus1.req0_ready, 0);
    @(negedge clk);
    drive_req1(1'b1, 1'b0, 8'h00, 8'h00);
    check("t4_mul_busy", bus1.busy, 1);
    check("t4_mul_valid_low", bus1.res_valid, 0);
    check("t4_mul_a", bus1.mul_a, 8'hFE);
    wait_res1(cyc);
    check("t4_second_latency", cyc, 1);
    check("t4_second_data", bus1.res_data, 8'h04);
    check("t4_second_id", bus1.res_id, 1);
    @(negedge clk);
    bus1.res_ready = 0;
    check("t4_idle", bus1.busy, 0);

    // Reset pulsed mid-MUL after a requester-0 accept (prio would be 1).
    do_reset();
    @(negedge clk);
    drive_req1(1'b0, 1'b1, 8'h11, 8'h02);
    @(negedge clk);
    check("t5_in_mul", bus1.busy, 1);
    bus1.req1_valid = 1;
    rst_n = 0;
    #1;
    check("t5_rst_busy", bus1.busy, 0);
    check("t5_rst_valid", bus1.res_valid, 0);
    check("t5_rst_data", bus1.res_data, 0);
    check("t5_rst_mul_a", bus1.mul_a, 0);
    check("t5_rst_mul_b", bus1.mul_b, 0);
    check("t5_rst_ready0", bus1.req0_ready, 0);
    check("t5_rst_ready1", bus1.req1_ready, 0);
    @(negedge clk);
    drive_req1(1'b0, 1'b0, 8'h00, 8'h00);
    drive_req1(1'b1, 1'b0, 8'h00, 8'h00);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_result", bus1.res_valid, 0);
    end
    drive_req1(1'b0, 1'b1, 8'h01, 8'h01);
    drive_req1(1'b1, 1'b1, 8'h02, 8'h02);
    #1;
    check("t5_prio_req0", bus1.req0_ready, 1);
    check("t5_prio_req1", bus1.req1_ready, 0);

    // MUL_LAT=3, back-to-back alternating requests, consumer never stalls.
    do_reset();
    oa[0] = 8'h02; ob[0] = 8'h03; exp6[0] = 8'h06;
    oa[1] = 8'hFB; ob[1] = 8'h04; exp6[1] = 8'hEC;
    @(negedge clk);
    bus3.req0_valid = 1; bus3.req0_a = oa[0]; bus3.req0_b = ob[0];
    bus3.req1_valid = 1; bus3.req1_a = oa[1]; bus3.req1_b = ob[1];
    bus3.res_ready  = 1;
    got  = 0;
    last = 0;
    j    = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus3.res_valid) begin
        check("t6_interval", c - last, 4);
        check("t6_data", bus3.res_data, exp6[j % 2]);
        check("t6_id", bus3.res_id, j % 2);
        last = c;
        j++;
        got++;
      end else begin
        check("t6_busy", bus3.busy, 1);
        check("t6_mul_a_stable", bus3.mul_a, oa[j % 2]);
        check("t6_mul_b_stable", bus3.mul_b, ob[j % 2]);
      end
    end
    check("t6_results", got, 7);
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
Controller that shares the single 8-bit signed multiplier in the ALU between two requesters.
- Arbitrates round-robin between two valid/ready request ports.
- Registers the winning operand pair and drives the shared multiplier's operand inputs.
- Waits a programmable settle time, captures the truncated 8-bit product, and returns it on one valid/ready result port tagged with the requester id.

Parameters:
- W, 8: operand and result width; must match the shared multiplier.
- MUL_LAT, 1: settle cycles allowed for the combinational multiplier; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  controller accepts requester 0 this cycle.
- req0_a  in  W  requester 0 multiplicand, two's complement.
- req0_b  in  W  requester 0 multiplier, two's complement.
- req1_valid, req1_ready, req1_a, req1_b: as above, for requester 1.
- mul_a  out  W  operand A to the shared multiplier.
- mul_b  out  W  operand B to the shared multiplier.
- mul_c  in  W  low W bits of the product from the shared multiplier.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  W  captured product.
- res_id  out  1  id (0/1) of the requester that owns res_data.
- busy  out  1  high in MUL or HOLD.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; prio=0; op_a=op_b=0; mul_a=mul_b=0; op_id=0.
  - res_valid=0; res_data=0; res_id=0; busy=0.
  - req0_ready=req1_ready=0 while rst_n is low.
- mul_a/mul_b are always driven from registers op_a/op_b, never combinationally from the request ports.
- States are IDLE, MUL and HOLD. A transfer happens on a port in any cycle where its valid and ready are both high.
- Grant (combinational, evaluated only when accepting is permitted):
  - only one requester valid: grant it;
  - both valid: grant the requester equal to prio;
  - neither valid: no grant.
- reqN_ready is high only for the granted requester. Accepting is permitted in IDLE, or in HOLD during the cycle res_ready=1.
- On accept:
  - op_a/op_b <= granted operands; op_id <= granted id;
  - prio <= ~granted id;
  - cnt <= MUL_LAT-1;
  - next state=MUL.
- MUL:
  - no request is accepted;
  - if cnt!=0, cnt decrements;
  - if cnt==0, res_data <= mul_c, res_id <= op_id, res_valid <= 1, next state=HOLD.
- HOLD:
  - res_valid, res_data and res_id are held stable until res_ready=1.
  - On res_ready=1 with a grant: accept the new pair (same rules as IDLE), res_valid <= 0, next state=MUL.
  - On res_ready=1 with no grant: res_valid <= 0, next state=IDLE.
- Latency: an accept at edge k gives res_valid high after edge k+MUL_LAT.
- Throughput: one result per MUL_LAT+1 cycles when the consumer never stalls.
- Arithmetic: the controller does no arithmetic. The result is the low W bits of the signed product; overflow wraps silently with no flag.
- Requester inputs are ignored when ready is low. A requester may drop valid before grant without affecting state.
- prio updates only on an accept, never on an idle cycle.
- Reset asserted mid-MUL or mid-HOLD discards the in-flight operation; no result is produced.
- busy = (state!=IDLE).

Decomposition:
- Package mul_share_pkg holds:
  - state encoding as 2-bit constants: IDLE=2'b00, MUL=2'b01, HOLD=2'b10; 2'b11 recovers to IDLE;
  - W default;
  - counter width CNT_W=4.
- One sub-module, rr_arb2: a two-input round-robin grant. Inputs are req[1:0], prio and enable; outputs are gnt[1:0] and gnt_id. It is purely combinational; prio stays in the parent.

Test Plan:
1. Reset, then req0 (a=8'hFD, b=8'h05) valid -> req0_ready=1; res_valid high MUL_LAT cycles later with res_data=8'hF1 (-15) and res_id=0.
2. Both requesters valid continuously after reset (req0 7*-2, req1 3*4) -> req0 served first with 8'hF2; then req1 with 8'h0C; grants alternate 0,1,0,1 with no starvation.
3. Truncation: 127*127 -> res_data=8'h01; 16*16 -> res_data=8'h00; -128*-1 -> res_data=8'h80.
4. Backpressure: res_ready low for 3 cycles in HOLD with req1 valid -> res_data and res_id stable, req1_ready=0; when res_ready rises, req1 is accepted in the same cycle and state goes to MUL.
5. rst_n pulsed low during MUL -> all outputs at reset values immediately; no res_valid after release; prio=0.
6. With MUL_LAT=3 and back-to-back requests from a consumer that never stalls -> res_valid every 4 cycles; mul_a/mul_b stable for the full MUL window.
